// File: rtl/xoodoo_nc_inv.sv
// Xoodoo-NC 96-bit inverse permutation, one inverse round per clock.
// Optional macro XOODOO_INV_UNROLL_EN: all rounds in a single RUN cycle.
module xoodoo_nc_inv #(
    parameter int ROUNDS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [95:0] in_state,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [95:0] out_state
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_e;

    fsm_e        fsm_q, fsm_d;
    logic [95:0] st_q, st_d;
    logic [3:0]  k_q, k_d;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] rc(input logic [3:0] i);
        logic [31:0] r;
        case (i)
            4'd0:    r = 32'h58;
            4'd1:    r = 32'h38;
            4'd2:    r = 32'h3C0;
            4'd3:    r = 32'hD0;
            4'd4:    r = 32'h120;
            4'd5:    r = 32'h14;
            4'd6:    r = 32'h60;
            4'd7:    r = 32'h2C;
            4'd8:    r = 32'h380;
            4'd9:    r = 32'hF0;
            4'd10:   r = 32'h1A0;
            4'd11:   r = 32'h12;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic logic [95:0] inv_round(input logic [95:0] s,
                                              input logic [31:0] c);
        logic [31:0] a0, a1, a2, b0, b1, b2;
        logic [31:0] q, y1, y2, y3, y4, p, e;
        a0 = s[31:0];
        a1 = rotl(s[63:32], 31);
        a2 = rotl(s[95:64], 24);
        b0 = ~a1 & a2;
        b1 = ~a2 & a0;
        b2 = ~a0 & a1;
        a0 = a0 ^ b0 ^ c;
        a1 = a1 ^ b1;
        a2 = rotl(a2 ^ b2, 21);
        q  = a0 ^ a1 ^ a2;
        y1 = q ^ rotl(q, 5) ^ rotl(q, 14);
        y2 = y1 ^ rotl(y1, 10) ^ rotl(y1, 28);
        y3 = y2 ^ rotl(y2, 20) ^ rotl(y2, 24);
        y4 = y3 ^ rotl(y3, 8) ^ rotl(y3, 16);
        p  = rotl(y4, 16);
        e  = rotl(p, 5) ^ rotl(p, 14);
        return {a2 ^ e, a1 ^ e, a0 ^ e};
    endfunction

`ifdef XOODOO_INV_UNROLL_EN
    function automatic logic [95:0] inv_all(input logic [95:0] s);
        logic [95:0] a;
        a = s;
        for (int r = 0; r < ROUNDS; r++) begin
            a = inv_round(a, rc(4'(11 - r)));
        end
        return a;
    endfunction
`endif

    // Next-state logic: latch in IDLE, invert in RUN, hold in DONE.
    always_comb begin
        fsm_d = fsm_q;
        st_d  = st_q;
        k_d   = k_q;
        unique case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    st_d  = in_state;
                    k_d   = '0;
                    fsm_d = RUN;
                end
            end
            RUN: begin
`ifdef XOODOO_INV_UNROLL_EN
                st_d  = inv_all(st_q);
                k_d   = 4'(ROUNDS);
                fsm_d = DONE;
`else
                st_d = inv_round(st_q, rc(4'd11 - k_q));
                k_d  = k_q + 4'd1;
                if (k_q == 4'(ROUNDS - 1)) begin
                    fsm_d = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State, datapath and round counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= IDLE;
            st_q  <= '0;
            k_q   <= '0;
        end else begin
            fsm_q <= fsm_d;
            st_q  <= st_d;
            k_q   <= k_d;
        end
    end

    assign in_ready  = (fsm_q == IDLE) && !rst;
    assign out_valid = (fsm_q == DONE);
    assign out_state = out_valid ? st_q : '0;

endmodule

// File: tb/tb_xoodoo_nc_inv.sv
// Scoreboard bench for xoodoo_nc_inv: forward Xoodoo-NC model feeds the
// inverse block, the monitor compares recovered states against originals.
module tb_xoodoo_nc_inv;

    localparam int ROUNDS = 3;
`ifdef XOODOO_INV_UNROLL_EN
    localparam int LAT = 1;
`else
    localparam int LAT = ROUNDS;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [95:0] in_state = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [95:0] out_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [95:0] sb[$];

    logic [31:0] RC[12] = '{
        32'h58, 32'h38, 32'h3C0, 32'hD0, 32'h120, 32'h14,
        32'h60, 32'h2C, 32'h380, 32'hF0, 32'h1A0, 32'h12
    };

    xoodoo_nc_inv #(.ROUNDS(ROUNDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_state (in_state),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_state(out_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Forward Xoodoo-NC: theta, rho-west, iota, chi, rho-east per round.
    function automatic logic [95:0] fwd(input logic [95:0] s);
        logic [31:0] a[3];
        logic [31:0] b[3];
        logic [31:0] p, e;
        a[0] = s[31:0];
        a[1] = s[63:32];
        a[2] = s[95:64];
        for (int r = 12 - ROUNDS; r < 12; r++) begin
            p = a[0] ^ a[1] ^ a[2];
            e = rl(p, 5) ^ rl(p, 14);
            for (int i = 0; i < 3; i++) a[i] = a[i] ^ e;
            a[2] = rl(a[2], 11);
            a[0] = a[0] ^ RC[r];
            for (int i = 0; i < 3; i++) begin
                b[i] = ~a[(i + 1) % 3] & a[(i + 2) % 3];
            end
            for (int i = 0; i < 3; i++) a[i] = a[i] ^ b[i];
            a[1] = rl(a[1], 1);
            a[2] = rl(a[2], 8);
        end
        return {a[2], a[1], a[0]};
    endfunction

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every output handshake.
    logic        stall = 1'b0;
    logic [95:0] held = '0;
    always @(negedge clk) begin
        if (rst) begin
            stall <= 1'b0;
        end else begin
            if (stall) begin
                chk("hold_valid", 96'(out_valid), 96'd1);
                chk("hold_state", out_state, held);
            end
            if (!out_valid) begin
                chk("zero_when_invalid", out_state, 96'd0);
            end else if (out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected none",
                             out_state);
                end else begin
                    chk("recovered", out_state, sb.pop_front());
                end
            end
            stall <= out_valid && !out_ready;
            held  <= out_state;
        end
    end

    task automatic send(input logic [95:0] orig, input bit keep,
                        output int acc_cyc);
        bit ok;
        int n;
        in_state = fwd(orig);
        in_valid = 1'b1;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept");
        end else begin
            sb.push_back(orig);
        end
        acc_cyc = cyc;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_out(output int c);
        c = 0;
        while (!out_valid && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
    endtask

    task automatic drain(input bit rnd);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("drain_empty", 96'(sb.size()), 96'd0);
    endtask

    logic [95:0] vec[3] = '{
        96'h0,
        96'h0000000000000000_00000001,
        96'hFFFFFFFF_12345678_DEADBEEF
    };

    initial begin
        int a;
        int c;
        int ac[4];
        logic [95:0] v;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 96'(in_ready), 96'd0);
        chk("rst_out_valid", 96'(out_valid), 96'd0);
        chk("rst_out_state", out_state, 96'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 96'(in_ready), 96'd1);

        // Loopback with latency check.
        for (int i = 0; i < 3; i++) begin
            send(vec[i], 1'b0, a);
            wait_out(c);
            chk("latency", 96'(c), 96'(LAT));
            drain(1'b0);
        end

        // Backpressure in DONE.
        out_ready = 1'b0;
        v = 96'hA5A5A5A5_0F0F0F0F_C3C3C3C3;
        send(v, 1'b0, a);
        wait_out(c);
        chk("bp_latency", 96'(c), 96'(LAT));
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 96'(out_valid), 96'd1);
            chk("bp_state", out_state, v);
            chk("bp_in_ready", 96'(in_ready), 96'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", 96'(in_ready), 96'd1);
        chk("bp_release_valid", 96'(out_valid), 96'd0);
        drain(1'b0);

        // Continuous in_valid: accepts spaced by LAT+2 cycles, in order.
        for (int i = 0; i < 4; i++) begin
            v = {$urandom, $urandom, $urandom};
            send(v, 1'b1, ac[i]);
        end
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            chk("stream_spacing", 96'(ac[i] - ac[i-1]), 96'(LAT + 2));
        end
        drain(1'b0);

        // Reset during the second RUN cycle.
        out_ready = 1'b0;
        send(96'h11111111_22222222_33333333, 1'b0, a);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 96'(in_ready), 96'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("midrst_idle", 96'(in_ready), 96'd1);
        chk("midrst_valid", 96'(out_valid), 96'd0);
        chk("midrst_state", out_state, 96'd0);
        out_ready = 1'b1;
        send(96'h0BADF00D_CAFEBABE_01234567, 1'b0, a);
        wait_out(c);
        chk("midrst_latency", 96'(c), 96'(LAT));
        drain(1'b0);

        // Random states with random backpressure.
        for (int i = 0; i < 500; i++) begin
            v = {$urandom, $urandom, $urandom};
            send(v, 1'b0, a);
            drain(1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
